// File: rtl/io_bus_if.sv
// Requester-side handshake bundle for io_bus_arbiter: two requesters sharing one
// completion/read-data return path.
interface io_bus_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [7:0]  addr0;
  logic [7:0]  addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [31:0] rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter between CPU (0) and loader (1) onto a decoded bus:
// output ports 0-7, synchronized input ports 8-9, wait-stated memory 10-255.
module io_bus_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  io_bus_if.slave     bus,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        port_we,
  output logic [2:0]  port_addr,
  output logic [31:0] port_wdata,
  input  logic [1:0]  in_ports,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  state_t      state;
  logic        last_grant;
  logic        gnt;
  logic [3:0]  wait_cnt;
  logic [1:0]  sync_q;
  logic [1:0]  sync_in;
  logic        g_we;
  logic [7:0]  g_addr;
  logic        pick;
  logic        sel_we;
  logic [7:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic        finish;
  logic [31:0] rd_val;

  function automatic logic is_mem(input logic [7:0] a);
    return a >= 8'd10;
  endfunction

  function automatic logic is_in(input logic [7:0] a);
    return a[7:1] == 7'd4;
  endfunction

  function automatic logic is_out(input logic [7:0] a);
    return a < 8'd8;
  endfunction

  always_comb begin
    pick = bus.req1;
    if (bus.req0 && bus.req1) pick = ~last_grant;
    else if (bus.req0)        pick = 1'b0;
    sel_we    = pick ? bus.we1    : bus.we0;
    sel_addr  = pick ? bus.addr1  : bus.addr0;
    sel_wdata = pick ? bus.wdata1 : bus.wdata0;
  end

  // Last strobe cycle: single-cycle ACCESS for ports, final WAIT cycle for memory.
  always_comb begin
    finish = 1'b0;
    if (state == ACCESS) finish = !(is_mem(g_addr) && (WAIT_CYCLES != 0));
    if (state == WAIT)   finish = (wait_cnt == 4'd0);
    rd_val = 32'h0;
    if (!g_we) begin
      if (is_mem(g_addr))     rd_val = mem_rdata;
      else if (is_in(g_addr)) rd_val = {31'b0, sync_in[g_addr[0]]};
    end
  end

  assign busy = (state != IDLE);

  // Granted payload is captured once; later requester changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && (bus.req0 || bus.req1)) begin
      g_we   <= sel_we;
      g_addr <= sel_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      wait_cnt   <= 4'd0;
      sync_q     <= 2'b00;
      sync_in    <= 2'b00;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.rdata  <= 32'h0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= 8'h0;
      mem_wdata  <= 32'h0;
      port_we    <= 1'b0;
      port_addr  <= 3'h0;
      port_wdata <= 32'h0;
    end else begin
      sync_q  <= in_ports;
      sync_in <= sync_q;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt   <= pick;
            state <= ACCESS;
            if (is_out(sel_addr) && sel_we) begin
              port_we    <= 1'b1;
              port_addr  <= sel_addr[2:0];
              port_wdata <= sel_wdata;
            end
            if (is_mem(sel_addr)) begin
              mem_we    <= sel_we;
              mem_re    <= !sel_we;
              mem_addr  <= sel_addr;
              mem_wdata <= sel_we ? sel_wdata : 32'h0;
            end
          end
        end
        ACCESS: begin
          port_we    <= 1'b0;
          port_addr  <= 3'h0;
          port_wdata <= 32'h0;
          if (!finish) begin
            state    <= WAIT;
            wait_cnt <= 4'(WAIT_CYCLES - 1);
          end
        end
        WAIT: begin
          if (!finish) wait_cnt <= wait_cnt - 4'd1;
        end
        ACK: begin
          bus.ack0   <= 1'b0;
          bus.ack1   <= 1'b0;
          bus.rdata  <= 32'h0;
          last_grant <= gnt;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (finish) begin
        state     <= ACK;
        bus.ack0  <= ~gnt;
        bus.ack1  <= gnt;
        bus.rdata <= rd_val;
        mem_we    <= 1'b0;
        mem_re    <= 1'b0;
        mem_addr  <= 8'h0;
        mem_wdata <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed and randomized bench for io_bus_arbiter against a transaction-level
// reference model (winner choice, latency, decode and expected read data).
module tb_io_bus_arbiter;
  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we, mem_re, port_we, busy;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, port_wdata;
  logic [2:0]  port_addr;
  logic [1:0]  in_ports;

  io_bus_if bus();

  io_bus_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .port_we(port_we), .port_addr(port_addr), .port_wdata(port_wdata),
    .in_ports(in_ports), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_content(input logic [7:0] a);
    if (a == 8'h20) return 32'h0000_1234;
    return {a, ~a, a ^ 8'h3C, 8'h5A};
  endfunction

  // Read data is only meaningful while the strobe is up.
  assign mem_rdata = mem_re ? mem_content(mem_addr) : 32'hDEAD_BEEF;

  int passes = 0;
  int total  = 0;

  bit          last_g = 1'b1;
  bit          pend   [2];
  bit          p_we   [2];
  logic [7:0]  p_addr [2];
  logic [31:0] p_wdata[2];
  logic [1:0]  in_val = 2'b00;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_cycle(input string tag, input logic [5:0] ectl, input logic [106:0] edat);
    check({tag, " ctl"}, {bus.ack0, bus.ack1, busy, mem_we, mem_re, port_we}, ectl);
    check({tag, " data"}, {mem_addr, mem_wdata, port_addr, port_wdata, bus.rdata}, edat);
  endtask

  task automatic drive_bus(input int r, input bit req, input bit we, input logic [7:0] a,
                           input logic [31:0] d);
    if (r == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic set_req(input int r, input bit we, input logic [7:0] a, input logic [31:0] d);
    pend[r] = 1'b1; p_we[r] = we; p_addr[r] = a; p_wdata[r] = d;
    drive_bus(r, 1'b1, we, a, d);
  endtask

  task automatic clear_req(input int r);
    pend[r] = 1'b0;
    if (r == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  task automatic rand_req(input int r);
    int          cls;
    logic [7:0]  a;
    cls = int'($urandom_range(0, 2));
    if (cls == 0)      a = 8'($urandom_range(0, 7));
    else if (cls == 1) a = 8'($urandom_range(8, 9));
    else               a = 8'($urandom_range(10, 255));
    set_req(r, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_cycle(tag, 6'b0, 107'b0);
    end
  endtask

  // One whole transaction as the model sees it: pick winner, expect strobes,
  // ack at cycle L counted from the sampling edge, then a clean idle cycle.
  task automatic serve(input bit keep, input bit drop_mid, input bit scramble, input string tag);
    int          win, L;
    bit          we, is_m, is_o, is_i, strobe, pw, ack;
    logic [7:0]  a;
    logic [31:0] d, rexp;
    if (pend[0] && pend[1]) win = last_g ? 0 : 1;
    else                    win = pend[0] ? 0 : 1;
    we = p_we[win]; a = p_addr[win]; d = p_wdata[win];
    is_m = (a >= 8'd10);
    is_o = (a < 8'd8);
    is_i = !is_m && !is_o;
    L = is_m ? 2 + W : 2;
    rexp = 32'h0;
    if (!we && is_m)      rexp = mem_content(a);
    else if (!we && is_i) rexp = {31'b0, in_val[a[0]]};
    for (int k = 1; k <= L; k++) begin
      @(posedge clk); #1;
      strobe = is_m && (k <= 1 + W);
      pw     = is_o && we && (k == 1);
      ack    = (k == L);
      check_cycle($sformatf("%s r%0d a%0h c%0d", tag, win, a, k),
                  {ack && win == 0, ack && win == 1, 1'b1, strobe && we, strobe && !we, pw},
                  {strobe ? a : 8'h0, (strobe && we) ? d : 32'h0, pw ? a[2:0] : 3'h0,
                   pw ? d : 32'h0, ack ? rexp : 32'h0});
      if (k == 1 && drop_mid) clear_req(win);
      if (k == 1 && scramble) drive_bus(win, 1'b1, ~we, 8'($urandom), $urandom);
    end
    last_g = win[0];
    if (!keep) clear_req(win);
    @(posedge clk); #1;
    check_cycle({tag, " idle"}, 6'b0, 107'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_bus(0, 1'b0, 1'b0, 8'h0, 32'h0);
    drive_bus(1, 1'b0, 1'b0, 8'h0, 32'h0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    in_ports = 2'b00;

    // Reset: outputs forced low asynchronously, held through clock edges.
    #2 rst = 1'b0;
    #1 check_cycle("reset async", 6'b0, 107'b0);
    idle(3, "reset held");
    rst = 1'b1;
    idle(2, "after reset");

    // Tie after reset: CPU first, then loader wins while req0 stays up.
    set_req(0, 1'b1, 8'd5, 32'h1111_0005);
    set_req(1, 1'b0, 8'h40, 32'h0);
    serve(1'b1, 1'b0, 1'b0, "tie1");
    serve(1'b0, 1'b0, 1'b0, "tie2");
    serve(1'b0, 1'b0, 1'b0, "tie3");

    // Output-port write and memory read examples.
    set_req(0, 1'b1, 8'd3, 32'h0000_00A5);
    serve(1'b0, 1'b0, 1'b0, "pwr");
    set_req(1, 1'b0, 8'h20, 32'h0);
    serve(1'b0, 1'b0, 1'b0, "mrd");

    // Synchronized input ports, port read, write to input address.
    in_ports = 2'b10; in_val = 2'b10;
    idle(4, "in settle");
    set_req(0, 1'b0, 8'd9, 32'h0);
    serve(1'b0, 1'b0, 1'b0, "in9");
    set_req(1, 1'b0, 8'd8, 32'h0);
    serve(1'b0, 1'b0, 1'b0, "in8");
    set_req(0, 1'b1, 8'd8, 32'hFFFF_FFFF);
    serve(1'b0, 1'b0, 1'b0, "wr8");
    set_req(1, 1'b0, 8'd2, 32'h0);
    serve(1'b0, 1'b0, 1'b0, "rd2");

    // Payload changed after grant, and req dropped mid-transaction.
    set_req(1, 1'b1, 8'h80, 32'h0BAD_F00D);
    serve(1'b0, 1'b0, 1'b1, "scramble");
    set_req(0, 1'b0, 8'h30, 32'h0);
    serve(1'b0, 1'b1, 1'b0, "dropmid");

    in_ports = 2'b01; in_val = 2'b01;
    idle(4, "in settle2");

    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1) rand_req(r);
      if (!pend[0] && !pend[1]) rand_req(int'($urandom_range(0, 1)));
      serve($urandom_range(0, 3) == 0, 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 4 && (pend[0] || pend[1]); i++) serve(1'b0, 1'b0, 1'b0, "drain");

    // Reset during a WAIT cycle drops the transaction.
    set_req(1, 1'b0, 8'h50, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midop wait strobe", {busy, mem_re, mem_addr}, {1'b1, 1'b1, 8'h50});
    rst = 1'b0;
    clear_req(1);
    #1 check_cycle("midop reset async", 6'b0, 107'b0);
    @(posedge clk); #1;
    check_cycle("midop reset held", 6'b0, 107'b0);
    last_g = 1'b1;
    #3 rst = 1'b1;
    set_req(0, 1'b1, 8'h60, 32'hCAFE_0001);
    serve(1'b0, 1'b0, 1'b0, "postrst");
    set_req(0, 1'b0, 8'h21, 32'h0);
    set_req(1, 1'b1, 8'd7, 32'h7777_7777);
    serve(1'b0, 1'b0, 1'b0, "postrst tie1");
    serve(1'b0, 1'b0, 1'b0, "postrst tie2");
    idle(2, "final");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
